// File: rtl/perf_counter_bank.sv
// Bank of RISC-V performance counters (cycle/time/instret/hpm) with CSR read/write decode.
// Reads are combinational; writes and increments commit at the next clk edge.
// No backpressure: every write strobe is accepted, and events are counted on the cycle they arrive.
module perf_counter_bank #(
  parameter int NUM_EVENTS    = 4,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     pipe_enable,
  input  logic                                     retire,
  input  logic [((NUM_EVENTS > 0) ? NUM_EVENTS : 1)-1:0] event_i,
  input  logic [11:0]                              csr_addr,
  output logic [31:0]                              csr_read_data,
  output logic                                     csr_illegal,
  input  logic                                     csr_write_enable,
  input  logic [11:0]                              csr_write_addr,
  input  logic [31:0]                              csr_write_data
);

  localparam int NC = NUM_EVENTS + 3;      // counter slots; slot 1 (time) aliases slot 0
  localparam int HW = COUNTER_WIDTH - 32;  // width of the upper half

  // Counters that physically exist; bit 1 is never set because time has no state of its own.
  function automatic logic [31:0] impl_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i == 0 || (i >= 2 && i < NC)) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [31:0] IMPL = impl_mask();

  logic [COUNTER_WIDTH-1:0] cnt_q [NC];
  logic [COUNTER_WIDTH-1:0] cnt_d [NC];
  logic [31:0]              inh_q, inh_d;
  logic [31:0]              ovf_q, ovf_d;

  logic [31:0] ovf_set;
  logic [31:0] inc_req;
  logic        wr_is_lo, wr_is_hi, wr_inh, wr_ovf;

  // Per-counter increment requests before inhibit; event k lands on slot k+3.
  always_comb begin
    inc_req    = 32'(event_i) << 3;
    inc_req[0] = 1'b1;
    inc_req[1] = 1'b0;
    inc_req[2] = retire && pipe_enable;
  end

  // Write decode: only machine aliases, mcountinhibit and the overflow register are writable.
  always_comb begin
    wr_is_lo = csr_write_enable && (csr_write_addr[11:5] == 7'h58);
    wr_is_hi = csr_write_enable && (csr_write_addr[11:5] == 7'h5C);
    wr_inh   = csr_write_enable && (csr_write_addr == 12'h320);
    wr_ovf   = csr_write_enable && (csr_write_addr == 12'h7C0);
  end

  // Next counter values: a write to either half replaces that half and drops the increment.
  always_comb begin
    ovf_set = '0;
    for (int n = 0; n < NC; n++) begin
      cnt_d[n] = cnt_q[n];
      if (n == 1) begin
        cnt_d[n] = '0;
      end else if (wr_is_lo && csr_write_addr[4:0] == 5'(n)) begin
        cnt_d[n][31:0] = csr_write_data;
      end else if (wr_is_hi && csr_write_addr[4:0] == 5'(n)) begin
        cnt_d[n][COUNTER_WIDTH-1:32] = csr_write_data[HW-1:0];
      end else if (inc_req[n] && !inh_q[n]) begin
        cnt_d[n] = cnt_q[n] + 1'b1;
        if (&cnt_q[n]) ovf_set[n] = 1'b1;
      end
    end
  end

  // Inhibit and sticky overflow flags; a new overflow beats a same-cycle clear.
  always_comb begin
    inh_d = wr_inh ? (csr_write_data & IMPL) : inh_q;
    ovf_d = ((ovf_q & ~(wr_ovf ? csr_write_data : 32'h0)) | ovf_set) & IMPL;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int n = 0; n < NC; n++) cnt_q[n] <= '0;
      inh_q <= '0;
      ovf_q <= '0;
    end else begin
      for (int n = 0; n < NC; n++) cnt_q[n] <= cnt_d[n];
      inh_q <= inh_d;
      ovf_q <= ovf_d;
    end
  end

  logic [4:0]  rd_sel;
  logic [4:0]  rd_eff;
  logic [63:0] rd_cnt;
  logic        rd_lo, rd_hi;

  // Combinational read mux; unimplemented hpm slots read zero but are still legal.
  always_comb begin
    rd_sel = csr_addr[4:0];
    rd_eff = (rd_sel == 5'd1) ? 5'd0 : rd_sel;
    rd_cnt = '0;
    for (int n = 0; n < NC; n++) begin
      if (n != 1 && rd_eff == 5'(n)) rd_cnt = 64'(cnt_q[n]);
    end
    rd_lo = (csr_addr[11:5] == 7'h60) || ((csr_addr[11:5] == 7'h58) && rd_sel != 5'd1);
    rd_hi = (csr_addr[11:5] == 7'h64) || ((csr_addr[11:5] == 7'h5C) && rd_sel != 5'd1);
    csr_read_data = '0;
    csr_illegal   = 1'b0;
    if (rd_lo) begin
      csr_read_data = rd_cnt[31:0];
    end else if (rd_hi) begin
      csr_read_data = rd_cnt[63:32];
    end else if (csr_addr == 12'h320) begin
      csr_read_data = inh_q;
    end else if (csr_addr == 12'h7C0) begin
      csr_read_data = {ovf_q[31:2], ovf_q[0], ovf_q[0]};
    end else begin
      csr_illegal = 1'b1;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 64-bit and a 40-bit instance share all stimulus.
// Reads are combinational, sampled 1ns after driving csr_addr, well away from the clock edge.
// Expected values go into a scoreboard queue when a read is issued and are popped on sampling.
`timescale 1ns/100ps
module tb_perf_counter_bank;

  logic        clk;
  logic        reset_n;
  logic        pipe_enable;
  logic        retire;
  logic [3:0]  event_i;
  logic [11:0] csr_addr;
  logic [31:0] csr_read_data, rd40;
  logic        csr_illegal, ill40;
  logic        csr_write_enable;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_write_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  perf_counter_bank #(.NUM_EVENTS(4), .COUNTER_WIDTH(64)) u_dut (
    .clk(clk), .reset_n(reset_n), .pipe_enable(pipe_enable), .retire(retire),
    .event_i(event_i), .csr_addr(csr_addr), .csr_read_data(csr_read_data),
    .csr_illegal(csr_illegal), .csr_write_enable(csr_write_enable),
    .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data)
  );

  perf_counter_bank #(.NUM_EVENTS(4), .COUNTER_WIDTH(40)) u_dut40 (
    .clk(clk), .reset_n(reset_n), .pipe_enable(pipe_enable), .retire(retire),
    .event_i(event_i), .csr_addr(csr_addr), .csr_read_data(rd40),
    .csr_illegal(ill40), .csr_write_enable(csr_write_enable),
    .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
    csr_addr = a;
    exp_q.push_back(e);
    #1;
    chk(tag, csr_read_data);
  endtask

  task automatic rd40c(input logic [11:0] a, input logic [31:0] e, input string tag);
    csr_addr = a;
    exp_q.push_back(e);
    #1;
    chk(tag, rd40);
  endtask

  task automatic ill(input logic [11:0] a, input logic e, input string tag);
    csr_addr = a;
    exp_q.push_back({31'b0, e});
    #1;
    chk(tag, {31'b0, csr_illegal});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_write_enable = 1'b1;
    csr_write_addr   = a;
    csr_write_data   = d;
    tick();
    csr_write_enable = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pipe_enable = 1'b0; retire = 1'b0; event_i = 4'b0;
    csr_addr = 12'h0; csr_write_enable = 1'b0; csr_write_addr = 12'h0; csr_write_data = 32'h0;
    tick(); tick();

    // Reset state
    rd(12'hC00, 32'h0, "rst_cycle_lo");
    rd(12'hC80, 32'h0, "rst_cycle_hi");
    rd(12'hC02, 32'h0, "rst_instret");
    rd(12'hC03, 32'h0, "rst_hpm3");
    rd(12'h320, 32'h0, "rst_inhibit");
    rd(12'h7C0, 32'h0, "rst_ovf");
    ill(12'hC00, 1'b0, "rst_ill_c00");

    // 10 idle cycles
    reset_n = 1'b1;
    repeat (10) tick();
    rd(12'hC00, 32'd10, "idle_cycle_lo");
    rd(12'hC80, 32'd0, "idle_cycle_hi");
    rd(12'hC01, 32'd10, "idle_time");
    rd(12'hC02, 32'd0, "idle_instret");
    rd40c(12'hC00, 32'd10, "idle_cycle40");

    // instret qualified by pipe_enable: pattern 1,0,1,1,0
    retire = 1'b1;
    pipe_enable = 1'b1; tick();
    pipe_enable = 1'b0; tick();
    pipe_enable = 1'b1; tick();
    pipe_enable = 1'b1; tick();
    pipe_enable = 1'b0; tick();
    retire = 1'b0;
    rd(12'hC02, 32'd3, "instret_user");
    rd(12'hB02, 32'd3, "instret_mach");

    // Decode legality
    rd(12'hC10, 32'd0, "unimpl_read_zero");
    ill(12'hC10, 1'b0, "ill_c10");
    ill(12'h321, 1'b1, "ill_321");
    ill(12'hB01, 1'b1, "ill_b01");
    ill(12'hB81, 1'b1, "ill_b81");
    ill(12'hB9F, 1'b0, "ill_b9f");
    ill(12'hCA0, 1'b1, "ill_ca0");

    // Carry across the 32-bit boundary
    wr(12'hB00, 32'hFFFF_FFFE);
    rd(12'hC00, 32'hFFFF_FFFE, "wr_lo_visible");
    wr(12'hB80, 32'h0);
    repeat (3) tick();
    rd(12'hC00, 32'd1, "carry_lo");
    rd(12'hC80, 32'd1, "carry_hi");
    rd(12'h7C0, 32'd0, "carry_no_ovf");
    rd40c(12'hC80, 32'd1, "carry_hi40");

    // Full wrap: sets ovf[0] with bit 1 mirroring; 40-bit upper half truncates
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hC80, 32'hFFFF_FFFF, "allones_hi");
    rd40c(12'hC80, 32'h0000_00FF, "allones_hi40");
    tick();
    rd(12'hC00, 32'd0, "wrap_lo");
    rd(12'hC80, 32'd0, "wrap_hi");
    rd(12'h7C0, 32'h3, "wrap_ovf");
    rd40c(12'hC80, 32'd0, "wrap_hi40");
    rd40c(12'h7C0, 32'h3, "wrap_ovf40");

    // Overflow set beats a same-cycle W1C, then a plain W1C clears
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'h7C0, 32'hFFFF_FFFF);
    rd(12'h7C0, 32'h3, "ovf_set_wins");
    wr(12'h7C0, 32'h1);
    rd(12'h7C0, 32'h0, "ovf_w1c");
    rd40c(12'h7C0, 32'h0, "ovf_w1c40");

    // Event counting and inhibit
    event_i = 4'b0100;
    repeat (7) tick();
    rd(12'hC05, 32'd7, "hpm5_count");
    event_i = 4'b0000;
    wr(12'h320, 32'h20);
    event_i = 4'b0100;
    repeat (4) tick();
    rd(12'hC05, 32'd7, "hpm5_inhibited");
    rd(12'h320, 32'h20, "inhibit_rb");
    wr(12'h320, 32'h0);
    rd(12'hC05, 32'd7, "inh_old_used");
    tick();
    rd(12'hC05, 32'd8, "inh_cleared");
    event_i = 4'b0000;

    // Write beats same-cycle increment; pre-write read returns old value
    event_i = 4'b0001;
    csr_write_enable = 1'b1; csr_write_addr = 12'hB03; csr_write_data = 32'd100;
    rd(12'hC03, 32'd0, "prewrite_read");
    tick();
    csr_write_enable = 1'b0;
    rd(12'hC03, 32'd100, "wr_beats_inc");
    tick();
    rd(12'hC03, 32'd101, "inc_after_wr");
    event_i = 4'b0000;
    wr(12'hC03, 32'd5);
    rd(12'hC03, 32'd101, "user_wr_ignored");

    // Inhibit mask hardwiring
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'h7D, "inhibit_mask");
    wr(12'hB00, 32'd50);
    wr(12'hB80, 32'd0);
    tick(); tick();
    rd(12'hC00, 32'd50, "cycle_inhibited");
    rd(12'hC01, 32'd50, "time_inhibited");
    rd40c(12'hC00, 32'd50, "cycle40_inhibited");
    wr(12'h320, 32'h4);
    tick();
    rd(12'hC00, 32'd51, "cycle_resumed");

    // Reset mid-count
    event_i = 4'b1111;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rd(12'hC00, 32'd0, "mid_rst_cycle");
    rd(12'hC80, 32'd0, "mid_rst_cycle_hi");
    rd(12'hC02, 32'd0, "mid_rst_instret");
    rd(12'hC03, 32'd0, "mid_rst_hpm3");
    rd(12'hC05, 32'd0, "mid_rst_hpm5");
    rd(12'h320, 32'd0, "mid_rst_inhibit");
    rd(12'h7C0, 32'd0, "mid_rst_ovf");
    rd40c(12'hC00, 32'd0, "mid_rst_cycle40");
    event_i = 4'b0000;
    tick();
    rd(12'hC00, 32'd1, "post_rst_cycle");
    rd(12'hC03, 32'd0, "post_rst_hpm3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of RISC-V performance counters: cycle, time, instret and NUM_EVENTS hpmcounters, each COUNTER_WIDTH bits wide. It replaces the core's hard-coded 64-bit cycle/instret counters and their fixed CSR decode. It adds writable machine-mode aliases, per-counter inhibit (mcountinhibit) and sticky overflow flags. It sits beside the MEM stage and serves CSR reads combinationally; writes commit at the clock edge.

## Interface
- NUM_EVENTS, 4, number of hpmcounters (hpmcounter3 upward); legal range 0..29.
- COUNTER_WIDTH, 64, width of every counter; legal range 33..64.
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- pipe_enable  in  1  pipeline advance strobe; qualifies `retire`.
- retire  in  1  WB instruction valid; instret counts `retire && pipe_enable`.
- event_i  in  max(NUM_EVENTS,1)  per-cycle event pulses; bit k feeds hpmcounter(k+3).
- csr_addr  in  12  CSR read address.
- csr_read_data  out  32  combinational read value.
- csr_illegal  out  1  combinational; 1 when csr_addr is not decoded by this block.
- csr_write_enable  in  1  write strobe, one cycle per write.
- csr_write_addr  in  12  CSR write address.
- csr_write_data  in  32  write value.

## Operation
- Counters:
  - C0 is cycle. It increments every cycle unless inhibit[0] is set.
  - C1 is time, a read-only alias of C0. It is never inhibited independently.
  - C2 is instret. It increments on `retire && pipe_enable && !inhibit[2]`.
  - C(k+3) increments on `event_i[k] && !inhibit[k+3]`. It is not gated by pipe_enable, so stall events are counted.
- Read map:
  - 0xC00+n returns C(n)[31:0], for n = 0..31.
  - 0xC80+n returns the high half, zero-extended from bit COUNTER_WIDTH-1 (COUNTER_WIDTH−32 bits).
  - Machine aliases read the same values: 0xB00+n and 0xB80+n, for n ≠ 1.
  - 0x320 returns mcountinhibit.
  - 0x7C0 returns the overflow flags.
  - Unimplemented hpmcounters (n > NUM_EVENTS+2) read 0 and are not illegal.
- Write map (writes are accepted only at 0xB00/0xB80 aliases, 0x320 and 0x7C0):
  - 0xB00+n replaces C(n)[31:0] and keeps the upper bits.
  - 0xB80+n replaces the upper COUNTER_WIDTH−32 bits with the truncated data.
  - 0x320 writes inhibit; bit 1 and bits of unimplemented counters are hardwired 0.
  - 0x7C0 is write-1-to-clear on the overflow flags.
  - Writes to the 0xC00/0xC80 user ranges, to 0xB01/0xB81, or to unimplemented counters are ignored with no side effect.
- csr_illegal is 1 for any csr_addr outside {0xC00–0xC1F, 0xC80–0xC9F, 0xB00, 0xB02–0xB1F, 0xB80, 0xB82–0xB9F, 0x320, 0x7C0}.
- Overflow: a counter holding all ones that increments wraps to 0 and sets its flag in ovf[n] (bit 1 mirrors bit 0). Flags are sticky.

## Timing
- Reset: all counters, inhibit and ovf are 0.
  - csr_read_data is 0 for every counter address.
  - csr_illegal reflects the decode of csr_addr.
  - A reset mid-count clears everything in that cycle; there is no increment on the reset edge.
- Increment latency: an event in cycle t is visible on a read in cycle t+1.
- A write in cycle t is visible on a read in cycle t+1. A read in cycle t of the same register returns the pre-write value.
- Write vs increment on the same counter in the same cycle: the written half takes csr_write_data and that cycle's increment is dropped entirely, with no carry into the other half.
- An inhibit write in cycle t affects increments from cycle t+1 onward; the increment in cycle t uses the old inhibit.
- An ovf set and a W1C clear of the same bit in the same cycle: the set wins.
- Carry crosses the 32-bit boundary within the same cycle; there is no split-half update.

## Test plan
- Reset, then 10 idle cycles -> read 0xC00 = 10 and 0xC80 = 0; read 0xC01 equals 0xC00; 0xC02 = 0.
- Drive 5 cycles of retire=1 with pipe_enable pattern 1,0,1,1,0 -> 0xC02 = 3; 0xB02 returns the same value.
- Write 0xB00 = 0xFFFF_FFFE and 0xB80 = 0 (COUNTER_WIDTH=64), wait 3 cycles -> 0xC00 = 1 and 0xC80 = 1; ovf = 0.
  - With COUNTER_WIDTH=40, write 0xB80 = 0xFF and 0xB00 = 0xFFFF_FFFF -> next cycle 0xC00 = 0, 0xC80 = 0, ovf[0] = 1; writing 0x7C0 = 1 clears ovf[0].
- NUM_EVENTS=4: pulse event_i[2] for 7 cycles -> 0xC05 = 7.
  - Write 0x320 = 0x20, then pulse event_i[2] 4 cycles -> 0xC05 stays 7.
  - Read 0xC10 -> 0 with csr_illegal = 0; read 0x321 -> csr_illegal = 1.
- Hold event_i[0]=1 and write 0xB03 = 100 in cycle t -> read in t+1 = 100, t+2 = 101.
  - Write 0xC03 -> no change.
  - Write 0x320 = 0xFFFF_FFFF -> readback 0x7D; bit 1 clear, bits 7+ clear.
- Apply reset_n=0 for one cycle mid-count with all counters nonzero -> every counter, inhibit and ovf read 0 the next cycle.
